fifo_read_ptr_ctrl: RTL and testbench

Parametrised read-side pointer controller for the synchronous FIFO, replacing the plain read-address counter. It supports non-power-of-two depths with a wrap bit, and derives empty, almost-empty and occupancy from the write pointer. It also provides mark/rewind (retransmit), a Gray-coded pointer copy, and underflow flagging. It sits between the FIFO read port logic and the memory read address.

---
 rtl/fifo_read_ptr_ctrl_if.sv | 28 ++
 rtl/fifo_read_ptr_ctrl.sv | 90 +++++++++
 tb/tb_fifo_read_ptr_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ptr_ctrl_if.sv
// Read-side handshake between the FIFO read port logic (master) and the read pointer controller.
// Pointers are {wrap, addr}; r_addr drops the wrap bit.
interface fifo_read_ptr_ctrl_if #(
    parameter int unsigned FIFO_ADDRESS_SIZE = 3
);
    logic                         rd_req;
    logic [FIFO_ADDRESS_SIZE:0]   w_ptr;
    logic                         mark;
    logic                         rewind;
    logic                         rd_en;
    logic [FIFO_ADDRESS_SIZE-1:0] r_addr;
    logic [FIFO_ADDRESS_SIZE:0]   r_ptr;
    logic [FIFO_ADDRESS_SIZE:0]   r_ptr_gray;
    logic                         empty;
    logic                         almost_empty;
    logic [FIFO_ADDRESS_SIZE:0]   count;
    logic                         underflow;

    modport master (
        output rd_req, w_ptr, mark, rewind,
        input  rd_en, r_addr, r_ptr, r_ptr_gray, empty, almost_empty, count, underflow
    );

    modport slave (
        input  rd_req, w_ptr, mark, rewind,
        output rd_en, r_addr, r_ptr, r_ptr_gray, empty, almost_empty, count, underflow
    );
endinterface

// File: rtl/fifo_read_ptr_ctrl.sv
// Read pointer controller for a synchronous FIFO of arbitrary depth: wrap-bit pointer, occupancy,
// empty/almost-empty, mark/rewind retransmit, Gray pointer copy and underflow pulse.
module fifo_read_ptr_ctrl #(
    parameter int unsigned MEMORY_DEPTH       = 4,
    parameter int unsigned FIFO_ADDRESS_SIZE  = 3,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
    input logic                 clk,
    input logic                 rst,
    fifo_read_ptr_ctrl_if.slave bus
);
    localparam int unsigned AW = FIFO_ADDRESS_SIZE;
    localparam int unsigned PW = FIFO_ADDRESS_SIZE + 1;

    localparam logic [PW-1:0] DEPTH_P     = PW'(MEMORY_DEPTH);
    localparam logic [PW-1:0] AE_LEVEL_P  = PW'(ALMOST_EMPTY_LEVEL);
    localparam logic [AW-1:0] LAST_ADDR_P = AW'(MEMORY_DEPTH - 1);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_gray_ptr;
    logic [PW-1:0] r_mark_ptr;
    logic          r_underflow;

    logic [AW-1:0] w_raddr;
    logic [AW-1:0] w_waddr;
    logic          w_empty;
    logic          w_rd_en;
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_inc_ptr;
    logic [PW-1:0] w_next_ptr;

    assign w_raddr = r_rd_ptr[AW-1:0];
    assign w_waddr = bus.w_ptr[AW-1:0];
    assign w_empty = (r_rd_ptr == bus.w_ptr);
    assign w_rd_en = bus.rd_req & ~w_empty;

    // Differing wrap bits mean the writer is one lap ahead; both branches stay within 0..DEPTH.
    always_comb begin
        w_count = '0;
        if (r_rd_ptr[AW] == bus.w_ptr[AW]) begin
            w_count = {1'b0, w_waddr} - {1'b0, w_raddr};
        end else begin
            w_count = DEPTH_P - {1'b0, w_raddr} + {1'b0, w_waddr};
        end
    end

    always_comb begin
        w_inc_ptr = r_rd_ptr;
        if (w_raddr == LAST_ADDR_P) begin
            w_inc_ptr = {~r_rd_ptr[AW], {AW{1'b0}}};
        end else begin
            w_inc_ptr = {r_rd_ptr[AW], w_raddr + 1'b1};
        end
    end

    always_comb begin
        w_next_ptr = r_rd_ptr;
        if (bus.rewind) begin
            w_next_ptr = r_mark_ptr;
        end else if (w_rd_en) begin
            w_next_ptr = w_inc_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_gray_ptr  <= '0;
            r_mark_ptr  <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_ptr    <= w_next_ptr;
            r_gray_ptr  <= w_next_ptr ^ (w_next_ptr >> 1);
            r_underflow <= bus.rd_req & w_empty & ~bus.rewind;
            // Captures the pre-increment pointer even when a read happens in the same cycle.
            if (bus.mark && !bus.rewind) begin
                r_mark_ptr <= r_rd_ptr;
            end
        end
    end

    assign bus.rd_en        = w_rd_en;
    assign bus.r_addr       = w_raddr;
    assign bus.r_ptr        = r_rd_ptr;
    assign bus.r_ptr_gray   = r_gray_ptr;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_empty = (w_count <= AE_LEVEL_P);
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_read_ptr_ctrl.sv
// Bench for fifo_read_ptr_ctrl: directed vector table and hand sequences on a depth-5 instance,
// Gray streaming and randomized runs on depth-5 and depth-8 instances against a position model.
module tb_fifo_read_ptr_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fifo_read_ptr_ctrl_if #(.FIFO_ADDRESS_SIZE(3)) bus5 ();
    fifo_read_ptr_ctrl_if #(.FIFO_ADDRESS_SIZE(3)) bus8 ();

    fifo_read_ptr_ctrl #(
        .MEMORY_DEPTH      (5),
        .FIFO_ADDRESS_SIZE (3),
        .ALMOST_EMPTY_LEVEL(1)
    ) u_dut5 (
        .clk(clk),
        .rst(rst),
        .bus(bus5.slave)
    );

    fifo_read_ptr_ctrl #(
        .MEMORY_DEPTH      (8),
        .FIFO_ADDRESS_SIZE (3),
        .ALMOST_EMPTY_LEVEL(1)
    ) u_dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int rd; int mk; int rw; int wp;
        int en; int ad;
        int rp; int cn; int em; int ae; int uf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rd, input int mk, input int rw, input int wp, input int en,
                       input int ad, input int rp, input int cn, input int em, input int ae,
                       input int uf);
        vec_t v;
        v.rd = rd; v.mk = mk; v.rw = rw; v.wp = wp; v.en = en; v.ad = ad;
        v.rp = rp; v.cn = cn; v.em = em; v.ae = ae; v.uf = uf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic mk, input logic rw,
                         input logic [3:0] wp);
        if (sel == 0) begin
            bus5.rd_req = rd; bus5.mark = mk; bus5.rewind = rw; bus5.w_ptr = wp;
        end else begin
            bus8.rd_req = rd; bus8.mark = mk; bus8.rewind = rw; bus8.w_ptr = wp;
        end
    endtask

    task automatic sample(input int sel, output logic en, output logic [2:0] ad,
                          output logic [3:0] rp, output logic [3:0] gp, output logic [3:0] cn,
                          output logic em, output logic ae, output logic uf);
        if (sel == 0) begin
            en = bus5.rd_en; ad = bus5.r_addr; rp = bus5.r_ptr; gp = bus5.r_ptr_gray;
            cn = bus5.count; em = bus5.empty; ae = bus5.almost_empty; uf = bus5.underflow;
        end else begin
            en = bus8.rd_en; ad = bus8.r_addr; rp = bus8.r_ptr; gp = bus8.r_ptr_gray;
            cn = bus8.count; em = bus8.empty; ae = bus8.almost_empty; uf = bus8.underflow;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Linear position 0..2*depth-1 encoded as {lap, position within lap}.
    function automatic logic [3:0] enc(input int pos, input int d);
        logic [3:0] e;
        e[3]   = (pos >= d);
        e[2:0] = 3'(pos % d);
        return e;
    endfunction

    function automatic logic [3:0] gray(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    logic       s_en, s_em, s_ae, s_uf;
    logic [2:0] s_ad;
    logic [3:0] s_rp, s_gp, s_cn;

    task automatic run_random(input int sel, input int n);
        int d, d2, rpos, wpos, mpos, cnt, old;
        logic rd, mk, rw, em, en, uf_e;
        logic [3:0] prev_g;
        d  = (sel == 0) ? 5 : 8;
        d2 = 2 * d;
        rst = 1'b1;
        drive(sel, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        rst = 1'b0;
        rpos = 0; wpos = 0; mpos = 0;
        prev_g = 4'h0;
        for (int i = 0; i < n; i++) begin
            if (((wpos - mpos + d2) % d2) < d && ($urandom % 2) == 1) wpos = (wpos + 1) % d2;
            rd  = (($urandom % 4) != 0);
            mk  = (($urandom % 8) == 0);
            rw  = (($urandom % 16) == 0);
            cnt = (wpos - rpos + d2) % d2;
            em  = (cnt == 0);
            en  = rd && !em;
            drive(sel, rd, mk, rw, enc(wpos, d));
            #1;
            sample(sel, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("rnd_rd_en", 32'(s_en), 32'(en));
            chk("rnd_r_addr", 32'(s_ad), 32'(rpos % d));
            chk("rnd_count", 32'(s_cn), 32'(cnt));
            chk("rnd_empty", 32'(s_em), 32'(em));
            chk("rnd_almost_empty", 32'(s_ae), 32'(cnt <= 1));
            uf_e = rd && em && !rw;
            old  = rpos;
            if (rw) rpos = mpos;
            else if (en) rpos = (rpos + 1) % d2;
            if (mk && !rw) mpos = old;
            tick();
            sample(sel, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("rnd_r_ptr", 32'(s_rp), 32'(enc(rpos, d)));
            chk("rnd_gray", 32'(s_gp), 32'(gray(enc(rpos, d))));
            chk("rnd_underflow", 32'(s_uf), 32'(uf_e));
            if (d == 8 && !rw && rpos != old) chk("rnd_gray_step", $countones(s_gp ^ prev_g), 1);
            prev_g = s_gp;
        end
    endtask

    initial begin
        logic [3:0] prev_g;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0);

        // Reset: second cycle holds rd_req high to show reset beats underflow.
        tick();
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        for (int s = 0; s < 2; s++) begin
            sample(s, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("rst_r_ptr", 32'(s_rp), 0);
            chk("rst_gray", 32'(s_gp), 0);
            chk("rst_count", 32'(s_cn), 0);
            chk("rst_empty", 32'(s_em), 1);
            chk("rst_almost_empty", 32'(s_ae), 1);
            chk("rst_rd_en", 32'(s_en), 0);
            chk("rst_underflow", 32'(s_uf), 0);
        end
        rst = 1'b0;

        // rd mk rw wp | en ad | rp cn em ae uf   (depth 5)
        add(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 1);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 0);
        add(1, 0, 0, 4'h8, 1, 0, 4'h1, 4, 0, 0, 0);
        add(1, 0, 0, 4'h8, 1, 1, 4'h2, 3, 0, 0, 0);
        add(1, 0, 0, 4'h8, 1, 2, 4'h3, 2, 0, 0, 0);
        add(1, 0, 0, 4'h8, 1, 3, 4'h4, 1, 0, 1, 0);
        add(1, 0, 0, 4'h8, 1, 4, 4'h8, 0, 1, 1, 0);
        add(1, 0, 0, 4'h8, 0, 0, 4'h8, 0, 1, 1, 1);
        add(1, 0, 0, 4'h0, 1, 0, 4'h9, 4, 0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 1, 4'hA, 3, 0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 2, 4'hB, 2, 0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 3, 4'hC, 1, 0, 1, 0);
        add(1, 0, 0, 4'h0, 1, 4, 4'h0, 0, 1, 1, 0);
        add(1, 0, 0, 4'h3, 1, 0, 4'h1, 2, 0, 0, 0);
        add(1, 0, 0, 4'h3, 1, 1, 4'h2, 1, 0, 1, 0);
        add(1, 0, 0, 4'h9, 1, 2, 4'h3, 3, 0, 0, 0);
        add(1, 0, 0, 4'h9, 1, 3, 4'h4, 2, 0, 0, 0);
        add(1, 0, 0, 4'h9, 1, 4, 4'h8, 1, 0, 1, 0);
        add(1, 0, 0, 4'h9, 1, 0, 4'h9, 0, 1, 1, 0);
        add(1, 0, 0, 4'h9, 0, 1, 4'h9, 0, 1, 1, 1);
        add(0, 0, 0, 4'h1, 0, 1, 4'h9, 5, 0, 0, 0);
        add(1, 1, 0, 4'h1, 1, 1, 4'hA, 4, 0, 0, 0);
        add(1, 0, 0, 4'h1, 1, 2, 4'hB, 3, 0, 0, 0);
        add(1, 1, 1, 4'h1, 1, 3, 4'h9, 5, 0, 0, 0);
        add(1, 0, 0, 4'h1, 1, 1, 4'hA, 4, 0, 0, 0);
        add(0, 0, 1, 4'h1, 0, 2, 4'h9, 5, 0, 0, 0);
        add(1, 0, 1, 4'h9, 0, 1, 4'h9, 0, 1, 1, 0);
        add(1, 0, 0, 4'h9, 0, 1, 4'h9, 0, 1, 1, 1);

        foreach (tbl[i]) begin
            drive(0, tbl[i].rd[0], tbl[i].mk[0], tbl[i].rw[0], tbl[i].wp[3:0]);
            #1;
            sample(0, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("tbl_rd_en", 32'(s_en), 32'(tbl[i].en));
            chk("tbl_r_addr", 32'(s_ad), 32'(tbl[i].ad));
            tick();
            sample(0, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("tbl_r_ptr", 32'(s_rp), 32'(tbl[i].rp));
            chk("tbl_gray", 32'(s_gp), 32'(gray(tbl[i].rp[3:0])));
            chk("tbl_count", 32'(s_cn), 32'(tbl[i].cn));
            chk("tbl_empty", 32'(s_em), 32'(tbl[i].em));
            chk("tbl_almost_empty", 32'(s_ae), 32'(tbl[i].ae));
            chk("tbl_underflow", 32'(s_uf), 32'(tbl[i].uf));
        end

        // Mid-operation reset: r_ptr=3 with mark=2, then reset while reading.
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 4'h4);
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 4'h4);
        tick();
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 4'h4);
        tick();
        sample(0, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
        chk("mid_pre_r_ptr", 32'(s_rp), 3);
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 4'h4);
        tick();
        sample(0, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
        chk("mid_rst_r_ptr", 32'(s_rp), 0);
        chk("mid_rst_gray", 32'(s_gp), 0);
        chk("mid_rst_underflow", 32'(s_uf), 0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b1, 4'h4);
        tick();
        sample(0, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
        chk("mid_rst_mark_cleared", 32'(s_rp), 0);
        chk("mid_rst_count", 32'(s_cn), 4);

        // Gray streaming on the power-of-two instance, writer kept three ahead.
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        rst = 1'b0;
        prev_g = 4'h0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 4'((i + 3) % 16));
            #1;
            sample(1, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("gray_rd_en", 32'(s_en), 1);
            chk("gray_r_addr", 32'(s_ad), 32'(i % 8));
            tick();
            sample(1, s_en, s_ad, s_rp, s_gp, s_cn, s_em, s_ae, s_uf);
            chk("gray_r_ptr", 32'(s_rp), 32'((i + 1) % 16));
            chk("gray_value", 32'(s_gp), 32'(gray(4'((i + 1) % 16))));
            chk("gray_step", $countones(s_gp ^ prev_g), 1);
            prev_g = s_gp;
        end

        run_random(0, 300);
        run_random(1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
